vram_arbiter: RTL and testbench

Single-port video RAM arbiter between display scanout and CPU. On each line request it bursts LINE_WORDS consecutive words from VRAM into the scanout line buffer, and it interleaves CPU read/write accesses in the free RAM slots. It sits between the GPU's VGA timing/scanout logic, the CPU bus bridge and the VRAM block. All RAM and line-buffer outputs are registered.

---
 rtl/vram_arbiter_if.sv | 50 +++++
 rtl/vram_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: line-fetch control, line-buffer write port, CPU port and RAM port.
// slave = arbiter side, master = surrounding GPU/CPU/VRAM side.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LB_AW  = 6
);
    logic              i_line_req;
    logic [ADDR_W-1:0] i_line_base;
    logic              o_line_busy;
    logic              o_line_done;
    logic              o_line_overrun;

    logic              o_lb_we;
    logic [LB_AW-1:0]  o_lb_addr;
    logic [DATA_W-1:0] o_lb_data;

    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_ack;
    logic [DATA_W-1:0] o_cpu_rdata;

    logic              o_ram_en;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [DATA_W-1:0] i_ram_rdata;

    modport slave (
        input  i_line_req, i_line_base,
        output o_line_busy, o_line_done, o_line_overrun,
        output o_lb_we, o_lb_addr, o_lb_data,
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output o_cpu_ack, o_cpu_rdata,
        output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata
    );

    modport master (
        output i_line_req, i_line_base,
        input  o_line_busy, o_line_done, o_line_overrun,
        input  o_lb_we, o_lb_addr, o_lb_data,
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_ack, o_cpu_rdata,
        input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: bursts scanout lines into the line buffer and fits CPU accesses
// into free slots. Define VRAM_ARB_CPU_SLOT_EN to force a CPU slot after SCAN_RUN scan reads.
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LINE_WORDS = 40,
    parameter int unsigned LB_AW      = 6,
    parameter int unsigned SCAN_RUN   = 8
) (
    input logic           i_clk,
    input logic           i_rst,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             is_cpu;
        logic             we;
        logic [LB_AW-1:0] idx;
    } tag_t;

    localparam logic [LB_AW-1:0] LastIdx = LB_AW'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LB_AW-1:0]  idx_q, idx_d;
    logic              cpu_pend_q, cpu_pend_d;
    tag_t              s1_q, s1_d, s2_q;

    logic              ram_en_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              lb_we_q;
    logic [LB_AW-1:0]  lb_addr_q;
    logic [DATA_W-1:0] lb_data_q;
    logic              line_done_q, line_busy_q, overrun_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    logic              line_accept;
    logic              cpu_elig;
    logic              force_cpu;
    logic              scan_issue;
    logic              cpu_issue;
    logic [ADDR_W-1:0] scan_addr;
    logic [LB_AW-1:0]  issue_idx;
    logic              s2_scan;
    logic              s2_cpu;

`ifdef VRAM_ARB_CPU_SLOT_EN
    localparam int unsigned RunW = $clog2(SCAN_RUN + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(SCAN_RUN);

    logic [RunW-1:0] run_q, run_d;

    // Saturates so a run that outlasts an idle CPU still forces the slot once it asks.
    always_comb begin
        run_d = '0;
        if (scan_issue) begin
            run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign force_cpu = (state_q == StScan) && (run_q == RunMax) && cpu_elig;
`else
    assign force_cpu = 1'b0;
`endif

    // A request in the ack cycle is the old transaction still holding req; ignore it.
    assign cpu_elig    = bus.i_cpu_req && !cpu_pend_q && !cpu_ack_q;
    assign line_accept = (state_q == StIdle) && bus.i_line_req;
    assign scan_issue  = line_accept || ((state_q == StScan) && !force_cpu);
    assign cpu_issue   = cpu_elig && !scan_issue;
    assign issue_idx   = line_accept ? '0 : idx_q;
    assign scan_addr   = line_accept ? bus.i_line_base : base_q + ADDR_W'(idx_q);
    assign s2_scan     = s2_q.valid && !s2_q.is_cpu;
    assign s2_cpu      = s2_q.valid && s2_q.is_cpu;

    // Word 0 is issued on the accepting edge itself, so the first read lands one cycle later.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_line_req) begin
                    state_d = StScan;
                    base_d  = bus.i_line_base;
                    idx_d   = LB_AW'(1);
                end
            end
            StScan: begin
                if (scan_issue) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (line_done_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_pend_d = cpu_pend_q;
        if (cpu_issue) begin
            cpu_pend_d = 1'b1;
        end else if (s2_cpu) begin
            cpu_pend_d = 1'b0;
        end

        s1_d        = '0;
        s1_d.valid  = scan_issue || cpu_issue;
        s1_d.is_cpu = cpu_issue;
        s1_d.we     = cpu_issue && bus.i_cpu_we;
        s1_d.idx    = issue_idx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            idx_q      <= '0;
            cpu_pend_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            cpu_pend_q <= cpu_pend_d;
            s1_q       <= s1_d;
            s2_q       <= s1_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
            line_done_q <= 1'b0;
            line_busy_q <= 1'b0;
            overrun_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            ram_en_q <= scan_issue || cpu_issue;
            ram_we_q <= cpu_issue && bus.i_cpu_we;
            if (scan_issue) begin
                ram_addr_q <= scan_addr;
            end else if (cpu_issue) begin
                ram_addr_q <= bus.i_cpu_addr;
            end
            if (cpu_issue && bus.i_cpu_we) begin
                ram_wdata_q <= bus.i_cpu_wdata;
            end

            lb_we_q <= s2_scan;
            if (s2_scan) begin
                lb_addr_q <= s2_q.idx;
                lb_data_q <= bus.i_ram_rdata;
            end
            line_done_q <= s2_scan && (s2_q.idx == LastIdx);

            cpu_ack_q   <= s2_cpu;
            cpu_rdata_q <= (s2_cpu && !s2_q.we) ? bus.i_ram_rdata : '0;

            line_busy_q <= (state_d != StIdle);
            overrun_q   <= bus.i_line_req && (state_q != StIdle);
        end
    end

    assign bus.o_line_busy    = line_busy_q;
    assign bus.o_line_done    = line_done_q;
    assign bus.o_line_overrun = overrun_q;
    assign bus.o_lb_we        = lb_we_q;
    assign bus.o_lb_addr      = lb_addr_q;
    assign bus.o_lb_data      = lb_data_q;
    assign bus.o_cpu_ack      = cpu_ack_q;
    assign bus.o_cpu_rdata    = cpu_rdata_q;
    assign bus.o_ram_en       = ram_en_q;
    assign bus.o_ram_we       = ram_we_q;
    assign bus.o_ram_addr     = ram_addr_q;
    assign bus.o_ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: line-buffer writes and CPU acks are matched against
// expectations queued when the stimulus is driven; a small RAM model backs the RAM port.
module tb_vram_arbiter;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned LINE_WORDS = 40;
    localparam int unsigned LB_AW      = 6;
    localparam int unsigned SCAN_RUN   = 8;
    localparam int          LW         = 40;

    typedef struct {
        logic [LB_AW-1:0]  idx;
        logic [DATA_W-1:0] data;
    } lb_exp_t;

    typedef struct {
        logic              is_read;
        logic [DATA_W-1:0] data;
    } cpu_exp_t;

    logic i_clk;
    logic i_rst;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LB_AW(LB_AW)) bus ();

    vram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LINE_WORDS(LINE_WORDS),
        .LB_AW     (LB_AW),
        .SCAN_RUN  (SCAN_RUN)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    // RAM model: unwritten words return a unique address-derived pattern.
    logic [DATA_W-1:0] mem     [2**ADDR_W];
    bit                mem_vld [2**ADDR_W];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {a, 1'b1} ^ 16'h3C5A;
    endfunction

    always @(posedge i_clk) begin
        if (bus.o_ram_en) begin
            bus.i_ram_rdata <= mem_vld[bus.o_ram_addr] ? mem[bus.o_ram_addr]
                                                        : pat(bus.o_ram_addr);
            if (bus.o_ram_we) begin
                mem[bus.o_ram_addr]     <= bus.o_ram_wdata;
                mem_vld[bus.o_ram_addr] <= 1'b1;
            end
        end
    end

    lb_exp_t  lb_q[$];
    cpu_exp_t cpu_q[$];
    int       cpu_slot_cycs[$];

    int n_pass, n_total, cyc;
    int done_cnt, done_cyc, ovr_cnt, ovr_cyc, ack_cnt, ack_cyc;
    int ram_wr_cnt, ram_rd_cnt;
    logic ack_now;
    logic [ADDR_W-1:0] cpu_watch;

    task automatic clear_counters();
        done_cnt = 0; done_cyc = 0; ovr_cnt = 0; ovr_cyc = 0;
        ack_cnt = 0; ack_cyc = 0; ram_wr_cnt = 0; ram_rd_cnt = 0;
        cpu_slot_cycs.delete();
    endtask

    task automatic push_line(input logic [ADDR_W-1:0] base);
        lb_exp_t e;
        for (int i = 0; i < LW; i++) begin
            e.idx  = LB_AW'(i);
            e.data = pat(base + ADDR_W'(i));
            lb_q.push_back(e);
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT produced in that cycle.
    task automatic cycle();
        lb_exp_t  e;
        cpu_exp_t c;
        @(negedge i_clk);
        cyc++;
        ack_now = 1'b0;
        if (bus.o_lb_we) begin
            n_total++;
            if (lb_q.size() == 0) begin
                $display("FAIL lb_write unexpected idx=%0d data=%h required none",
                         bus.o_lb_addr, bus.o_lb_data);
            end else begin
                e = lb_q.pop_front();
                if (bus.o_lb_addr !== e.idx || bus.o_lb_data !== e.data)
                    $display("FAIL lb_write got idx=%0d data=%h required idx=%0d data=%h",
                             bus.o_lb_addr, bus.o_lb_data, e.idx, e.data);
                else n_pass++;
            end
        end
        if (bus.o_cpu_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            ack_now = 1'b1;
            n_total++;
            if (cpu_q.size() == 0) begin
                $display("FAIL cpu_ack unexpected rdata=%h required none", bus.o_cpu_rdata);
            end else begin
                c = cpu_q.pop_front();
                if (c.is_read && bus.o_cpu_rdata !== c.data)
                    $display("FAIL cpu_rdata got %h required %h", bus.o_cpu_rdata, c.data);
                else n_pass++;
            end
        end
        if (bus.o_line_done) begin done_cnt++; done_cyc = cyc; end
        if (bus.o_line_overrun) begin ovr_cnt++; ovr_cyc = cyc; end
        if (bus.o_ram_en && bus.o_ram_we) ram_wr_cnt++;
        if (bus.o_ram_en && !bus.o_ram_we) ram_rd_cnt++;
        if (bus.o_ram_en && bus.o_ram_addr == cpu_watch) cpu_slot_cycs.push_back(cyc);
    endtask

    task automatic check_outputs_zero(input string name);
        logic [75:0] outs;
        outs = {bus.o_line_busy, bus.o_line_done, bus.o_line_overrun, bus.o_lb_we,
                bus.o_lb_addr, bus.o_lb_data, bus.o_cpu_ack, bus.o_cpu_rdata,
                bus.o_ram_en, bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata};
        n_total++;
        if (outs !== '0) $display("FAIL %s outputs=%h required 0", name, outs);
        else n_pass++;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus.i_line_req = 1'b0; bus.i_line_base = '0;
        bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
        cycle(); cycle();
        check_outputs_zero("reset_outputs");
        i_rst = 1'b0;
        cycle(); cycle();
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_line_wrap();
        int s;
        clear_counters();
        cpu_watch = 15'h0123;
        push_line(15'h7FF0);
        bus.i_line_base = 15'h7FF0;
        bus.i_line_req  = 1'b1;
        s = cyc;
        cycle();
        bus.i_line_req = 1'b0;
        n_total++;
        if (bus.o_line_busy !== 1'b1 || bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== 15'h7FF0)
            $display("FAIL wrap_first_read busy=%b en=%b addr=%h required 1 1 7ff0",
                     bus.o_line_busy, bus.o_ram_en, bus.o_ram_addr);
        else n_pass++;
        for (int k = 0; k < 80 && done_cnt == 0; k++) begin
            cycle();
            if (cyc == s + 17) begin
                n_total++;
                if (bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== 15'h0000)
                    $display("FAIL wrap_addr en=%b addr=%h required 1 0000",
                             bus.o_ram_en, bus.o_ram_addr);
                else n_pass++;
            end
        end
        n_total++;
        if (done_cnt != 1 || done_cyc - s != LW + 2)
            $display("FAIL wrap_done count=%0d cycle=%0d required 1 %0d",
                     done_cnt, done_cyc - s, LW + 2);
        else n_pass++;
        n_total++;
        if (bus.o_line_busy !== 1'b1) $display("FAIL busy_at_done got %b required 1",
                                               bus.o_line_busy);
        else n_pass++;
        cycle();
        n_total++;
        if (bus.o_line_busy !== 1'b0) $display("FAIL busy_after_done got %b required 0",
                                               bus.o_line_busy);
        else n_pass++;
        n_total++;
        if (lb_q.size() != 0 || ram_rd_cnt != LW)
            $display("FAIL wrap_lb_left left=%0d reads=%0d required 0 %0d",
                     lb_q.size(), ram_rd_cnt, LW);
        else n_pass++;
    endtask

    task automatic test_cpu_rw();
        cpu_exp_t c;
        int s;
        clear_counters();
        c.is_read = 1'b0; c.data = '0;
        cpu_q.push_back(c);
        bus.i_cpu_addr = 15'h0123; bus.i_cpu_wdata = 16'hBEEF; bus.i_cpu_we = 1'b1;
        bus.i_cpu_req = 1'b1;
        s = cyc;
        for (int k = 0; k < 12 && ack_cnt == 0; k++) cycle();
        bus.i_cpu_req = 1'b0;
        n_total++;
        if (ack_cnt != 1 || ack_cyc - s != 3)
            $display("FAIL cpu_write_latency acks=%0d cycles=%0d required 1 3",
                     ack_cnt, ack_cyc - s);
        else n_pass++;
        for (int k = 0; k < 6; k++) cycle();
        n_total++;
        if (ack_cnt != 1 || ram_wr_cnt != 1)
            $display("FAIL cpu_write_count acks=%0d writes=%0d required 1 1",
                     ack_cnt, ram_wr_cnt);
        else n_pass++;

        clear_counters();
        c.is_read = 1'b1; c.data = 16'hBEEF;
        cpu_q.push_back(c);
        bus.i_cpu_we = 1'b0; bus.i_cpu_req = 1'b1;
        s = cyc;
        for (int k = 0; k < 12 && ack_cnt == 0; k++) cycle();
        bus.i_cpu_req = 1'b0;
        n_total++;
        if (ack_cnt != 1 || ack_cyc - s != 3)
            $display("FAIL cpu_read_latency acks=%0d cycles=%0d required 1 3",
                     ack_cnt, ack_cyc - s);
        else n_pass++;
        for (int k = 0; k < 6; k++) cycle();
        n_total++;
        if (ack_cnt != 1 || ram_wr_cnt != 0 || cpu_q.size() != 0)
            $display("FAIL cpu_read_count acks=%0d writes=%0d left=%0d required 1 0 0",
                     ack_cnt, ram_wr_cnt, cpu_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        cpu_exp_t c;
        int t[3];
        int n;
        int s;
        clear_counters();
        c.is_read = 1'b1; c.data = 16'hBEEF;
        cpu_q.push_back(c);
        bus.i_cpu_addr = 15'h0123; bus.i_cpu_we = 1'b0; bus.i_cpu_req = 1'b1;
        s = cyc;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            cycle();
            if (ack_now) begin
                t[n] = cyc;
                n++;
                if (n < 3) cpu_q.push_back(c);
                else bus.i_cpu_req = 1'b0;
            end
        end
        bus.i_cpu_req = 1'b0;
        n_total++;
        if (n != 3 || t[0] - s != 3 || t[1] - t[0] != 4 || t[2] - t[1] != 4)
            $display("FAIL cpu_throughput acks=%0d first=%0d gaps=%0d,%0d required 3 3 4,4",
                     n, t[0] - s, t[1] - t[0], t[2] - t[1]);
        else n_pass++;
        for (int k = 0; k < 6; k++) cycle();
    endtask

    task automatic test_cpu_during_line();
        cpu_exp_t c;
        int s, exp_done, exp_first, exp_scan, scan_slots;
`ifdef VRAM_ARB_CPU_SLOT_EN
        exp_done = LW + 6; exp_first = SCAN_RUN + 1; exp_scan = 4;
`else
        exp_done = LW + 2; exp_first = LW + 1; exp_scan = 0;
`endif
        clear_counters();
        cpu_watch = 15'h0123;
        c.is_read = 1'b1; c.data = 16'hBEEF;
        push_line(15'h2000);
        cpu_q.push_back(c);
        bus.i_line_base = 15'h2000; bus.i_line_req = 1'b1;
        bus.i_cpu_addr = 15'h0123; bus.i_cpu_we = 1'b0; bus.i_cpu_req = 1'b1;
        s = cyc;
        cycle();
        bus.i_line_req = 1'b0;
        for (int k = 0; k < 150 && bus.i_cpu_req; k++) begin
            cycle();
            if (ack_now) begin
                if (done_cnt > 0) bus.i_cpu_req = 1'b0;
                else cpu_q.push_back(c);
            end
        end
        bus.i_cpu_req = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        scan_slots = 0;
        foreach (cpu_slot_cycs[i]) if (cpu_slot_cycs[i] <= done_cyc - 2) scan_slots++;
        n_total++;
        if (done_cnt != 1 || done_cyc - s != exp_done)
            $display("FAIL shared_done count=%0d cycle=%0d required 1 %0d",
                     done_cnt, done_cyc - s, exp_done);
        else n_pass++;
        n_total++;
        if (cpu_slot_cycs.size() == 0 || cpu_slot_cycs[0] - s != exp_first)
            $display("FAIL first_cpu_slot slots=%0d cycle=%0d required %0d",
                     cpu_slot_cycs.size(),
                     cpu_slot_cycs.size() == 0 ? -1 : cpu_slot_cycs[0] - s, exp_first);
        else n_pass++;
        n_total++;
        if (scan_slots != exp_scan)
            $display("FAIL cpu_slots_in_scan got %0d required %0d", scan_slots, exp_scan);
        else n_pass++;
        n_total++;
        if (lb_q.size() != 0 || cpu_q.size() != 0)
            $display("FAIL shared_left lb=%0d cpu=%0d required 0 0", lb_q.size(), cpu_q.size());
        else n_pass++;
    endtask

    task automatic test_overrun();
        int s, rd_before;
        clear_counters();
        push_line(15'h1000);
        bus.i_line_base = 15'h1000; bus.i_line_req = 1'b1;
        s = cyc;
        cycle();
        bus.i_line_req = 1'b0;
        while (cyc < s + 5) cycle();
        bus.i_line_base = 15'h3000; bus.i_line_req = 1'b1;
        cycle();
        bus.i_line_req = 1'b0;
        n_total++;
        if (bus.o_line_overrun !== 1'b1 || ovr_cyc != s + 6)
            $display("FAIL overrun_busy got %b at %0d required 1 at %0d",
                     bus.o_line_overrun, ovr_cyc - s, 6);
        else n_pass++;
        for (int k = 0; k < 80 && done_cnt == 0; k++) cycle();
        // Request lands in the done cycle, while busy is still high.
        bus.i_line_base = 15'h5000; bus.i_line_req = 1'b1;
        cycle();
        bus.i_line_req = 1'b0;
        rd_before = ram_rd_cnt;
        n_total++;
        if (bus.o_line_overrun !== 1'b1 || bus.o_line_busy !== 1'b0)
            $display("FAIL overrun_at_done ovr=%b busy=%b required 1 0",
                     bus.o_line_overrun, bus.o_line_busy);
        else n_pass++;
        for (int k = 0; k < 10; k++) cycle();
        n_total++;
        if (ovr_cnt != 2 || done_cnt != 1 || done_cyc - s != LW + 2)
            $display("FAIL overrun_counts ovr=%0d done=%0d at %0d required 2 1 %0d",
                     ovr_cnt, done_cnt, done_cyc - s, LW + 2);
        else n_pass++;
        n_total++;
        if (lb_q.size() != 0 || ram_rd_cnt != rd_before || ram_rd_cnt != LW)
            $display("FAIL overrun_reads left=%0d reads=%0d required 0 %0d",
                     lb_q.size(), ram_rd_cnt, LW);
        else n_pass++;
    endtask

    task automatic test_reset_midburst();
        int s;
        clear_counters();
        push_line(15'h0400);
        bus.i_line_base = 15'h0400; bus.i_line_req = 1'b1;
        s = cyc;
        cycle();
        bus.i_line_req = 1'b0;
        while (cyc < s + 21) cycle();
        i_rst = 1'b1;
        #1;
        check_outputs_zero("reset_midburst");
        lb_q.delete();
        cycle(); cycle();
        i_rst = 1'b0;
        for (int k = 0; k < 8; k++) cycle();
        n_total++;
        if (done_cnt != 0 || bus.o_line_busy !== 1'b0)
            $display("FAIL aborted_line done=%0d busy=%b required 0 0",
                     done_cnt, bus.o_line_busy);
        else n_pass++;

        clear_counters();
        push_line(15'h0400);
        bus.i_line_req = 1'b1;
        s = cyc;
        cycle();
        bus.i_line_req = 1'b0;
        n_total++;
        if (bus.o_ram_addr !== 15'h0400 || bus.o_ram_en !== 1'b1)
            $display("FAIL restart_addr en=%b addr=%h required 1 0400",
                     bus.o_ram_en, bus.o_ram_addr);
        else n_pass++;
        for (int k = 0; k < 80 && done_cnt == 0; k++) cycle();
        cycle();
        n_total++;
        if (done_cnt != 1 || done_cyc - s != LW + 2 || lb_q.size() != 0)
            $display("FAIL restart_line done=%0d at %0d left=%0d required 1 %0d 0",
                     done_cnt, done_cyc - s, lb_q.size(), LW + 2);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        cpu_watch = 15'h0123;
        clear_counters();
        test_reset();
        test_line_wrap();
        test_cpu_rw();
        test_back_to_back();
        test_cpu_during_line();
        test_overrun();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
